ntt_layer_scheduler: RTL and testbench

- Full-transform sequencer for the Kyber 256-point NTT/INTT datapath (coefficient RAM, zeta ROM, pipelined butterfly).
- Runs all 7 layers, issuing one butterfly per cycle.
- Generates read, zeta and delayed write-back addresses, and drains the butterfly pipeline at each layer boundary to avoid read-after-write hazards.
- Sits between the top-level command logic (start/inverse) and the memory wrapper, which exposes 2 read + 2 write ports.

---
 rtl/ntt_pkg.sv | 49 ++++
 rtl/ntt_addr_delay.sv | 31 +++
 rtl/ntt_layer_scheduler.sv | 147 ++++++++++++++
 tb/tb_ntt_layer_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types, sizes and butterfly address math for the Kyber NTT layer scheduler.
package ntt_pkg;
    localparam int KYBER_N      = 256;
    localparam int NUM_LAYERS   = 7;
    localparam int BF_PER_LAYER = KYBER_N / 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] addr_a;
        logic [7:0] addr_b;
        logic [6:0] zeta;
    } bf_addr_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] addr_a;
        logic [7:0] addr_b;
    } wb_t;

    // Butterfly idx of a layer -> (j, j+len, k); s = log2(len) shrinks forward, grows inverse.
    function automatic bf_addr_t bf_addr(input logic [2:0] layer, input logic [6:0] idx,
                                         input logic inv);
        bf_addr_t   r;
        logic [3:0] s;
        logic [7:0] ii;
        logic [7:0] len;
        logic [7:0] g;
        logic [7:0] j;
        logic [6:0] kf;
        logic [6:0] ki;
        ii  = {1'b0, idx};
        s   = inv ? ({1'b0, layer} + 4'd1) : (4'd7 - {1'b0, layer});
        len = 8'd1 << s;
        g   = ii >> s;
        j   = (g << (s + 4'd1)) | (ii & (len - 8'd1));
        kf  = 7'((8'd128 >> s) + g);
        ki  = 7'((8'd128 >> (s - 4'd1)) - 8'd1 - g);
        r.addr_a = j;
        r.addr_b = j + len;
        r.zeta   = inv ? ki : kf;
        return r;
    endfunction
endpackage

// File: rtl/ntt_addr_delay.sv
// Write-back delay line: carries {valid, addr_a, addr_b} from read issue to write-back.
module ntt_addr_delay
    import ntt_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  wb_t  din,
    output wb_t  dout
);
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
            wb_t q_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) q_reg <= '0;
                    else     q_reg <= din;
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) q_reg <= '0;
                    else     q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign dout = g_stage[PIPE_LAT-1].q_reg;
endmodule

// File: rtl/ntt_layer_scheduler.sv
// Sequences all seven NTT/INTT layers: one butterfly read per cycle, pipeline drained at
// every layer boundary so the next layer never reads a coefficient still in flight.
module ntt_layer_scheduler
    import ntt_pkg::*;
#(
    parameter int PIPE_LAT = 3,
    parameter int N_LOG2   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inverse,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [6:0]        zeta_addr,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b,
    output logic              bf_inverse,
    output logic [2:0]        layer,
    output logic              busy,
    output logic              done
);
    localparam logic [2:0] DRAIN_LAST = 3'(PIPE_LAT - 1);
    localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [6:0] LAST_BF    = 7'(BF_PER_LAYER - 1);

    state_t     state_reg, state_next;
    logic [6:0] i_reg, i_next;
    logic [2:0] drain_reg, drain_next;
    logic [2:0] layer_reg, layer_next;
    logic       inv_reg, inv_next;

    logic       rd_en_reg, rd_en_next;
    logic [7:0] rd_addr_a_reg, rd_addr_a_next;
    logic [7:0] rd_addr_b_reg, rd_addr_b_next;
    logic [6:0] zeta_reg, zeta_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    bf_addr_t   bf;
    wb_t        wb_in, wb_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            i_reg     <= '0;
            drain_reg <= '0;
            layer_reg <= '0;
            inv_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            drain_reg <= drain_next;
            layer_reg <= layer_next;
            inv_reg   <= inv_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        drain_next = drain_reg;
        layer_next = layer_reg;
        inv_next   = inv_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    inv_next   = inverse;
                    layer_next = '0;
                    i_next     = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                i_next = i_reg + 7'd1;
                if (i_reg == LAST_BF) begin
                    drain_next = '0;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_next = drain_reg + 3'd1;
                if (drain_reg == DRAIN_LAST) begin
                    if (layer_reg < LAST_LAYER) begin
                        layer_next = layer_reg + 3'd1;
                        i_next     = '0;
                        state_next = ST_ISSUE;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Addresses are zeroed outside ISSUE so idle buses stay quiet.
    always_comb begin
        bf             = bf_addr(layer_reg, i_reg, inv_reg);
        rd_en_next     = (state_reg == ST_ISSUE);
        rd_addr_a_next = rd_en_next ? bf.addr_a : '0;
        rd_addr_b_next = rd_en_next ? bf.addr_b : '0;
        zeta_next      = rd_en_next ? bf.zeta : '0;
        busy_next      = (state_reg == ST_IDLE) ? start : (state_reg != ST_DONE);
        done_next      = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_reg     <= 1'b0;
            rd_addr_a_reg <= '0;
            rd_addr_b_reg <= '0;
            zeta_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            rd_en_reg     <= rd_en_next;
            rd_addr_a_reg <= rd_addr_a_next;
            rd_addr_b_reg <= rd_addr_b_next;
            zeta_reg      <= zeta_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign wb_in = {rd_en_reg, rd_addr_a_reg, rd_addr_b_reg};

    ntt_addr_delay #(.PIPE_LAT(PIPE_LAT)) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (wb_in),
        .dout (wb_out)
    );

    assign rd_en      = rd_en_reg;
    assign rd_addr_a  = rd_addr_a_reg;
    assign rd_addr_b  = rd_addr_b_reg;
    assign zeta_addr  = zeta_reg;
    assign wr_en      = wb_out.valid;
    assign wr_addr_a  = wb_out.addr_a;
    assign wr_addr_b  = wb_out.addr_b;
    assign bf_inverse = inv_reg;
    assign layer      = layer_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
endmodule

// File: tb/tb_ntt_layer_scheduler.sv
// Bench for ntt_layer_scheduler: scoreboard of issues/write-backs from a reference loop model.
`timescale 1ns/1ps
module tb_ntt_layer_scheduler;
    localparam int P  = 3;
    localparam int P1 = 1;
    localparam int LAYER_CYC = 128 + P;

    logic clk = 1'b0;
    logic rst, start, inverse;
    logic rd_en, wr_en, bf_inverse, busy, done;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] zeta_addr;
    logic [2:0] layer;
    logic rd_en_1, wr_en_1, bf_inverse_1, busy_1, done_1;
    logic [7:0] rd_addr_a_1, rd_addr_b_1, wr_addr_a_1, wr_addr_b_1;
    logic [6:0] zeta_addr_1;
    logic [2:0] layer_1;

    always #5 clk = ~clk;

    ntt_layer_scheduler #(.PIPE_LAT(P), .N_LOG2(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .zeta_addr(zeta_addr),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .bf_inverse(bf_inverse), .layer(layer), .busy(busy), .done(done));

    ntt_layer_scheduler #(.PIPE_LAT(P1), .N_LOG2(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse),
        .rd_en(rd_en_1), .rd_addr_a(rd_addr_a_1), .rd_addr_b(rd_addr_b_1), .zeta_addr(zeta_addr_1),
        .wr_en(wr_en_1), .wr_addr_a(wr_addr_a_1), .wr_addr_b(wr_addr_b_1),
        .bf_inverse(bf_inverse_1), .layer(layer_1), .busy(busy_1), .done(done_1));

    typedef struct { int t; int a; int b; int z; int l; } iss_t;
    typedef struct { logic inv; int pulse_rel; int rst_rel; logic b2b; int exp_done; int exp_done1; } run_t;
    typedef struct { logic inv; int rel; logic en; int a; int b; int z; } spot_t;

    iss_t  rd_q[$];
    iss_t  wr_q[$];
    run_t  runs[5];
    spot_t spots[9];
    int    checks = 0;
    int    errors = 0;
    int    edge_n = 0;
    int    wcnt[256];
    logic  mon_on = 1'b0;
    logic  run_active = 1'b0;
    logic  run_inv = 1'b0;
    int    run_base = 0;
    logic        pend_v[P];
    logic [7:0]  pend_a[P];
    logic [7:0]  pend_b[P];
    logic [16:0] hist1[P1];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [63:0] pk(input int t, input int a, input int b, input int z, input int l);
        return {16'(t), 16'(a), 16'(b), 8'(z), 8'(l)};
    endfunction

    // Reference order: Kyber reference ntt/invntt loop nest, one butterfly per issue cycle.
    task automatic build_model(input logic inv, input int base);
        int k, n, len;
        rd_q.delete();
        wr_q.delete();
        k = inv ? 127 : 1;
        for (int lay = 0; lay < 7; lay++) begin
            len = inv ? (2 << lay) : (128 >> lay);
            n = 0;
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    iss_t e;
                    e.t = base + 1 + lay * LAYER_CYC + n;
                    e.a = j; e.b = j + len; e.z = k; e.l = lay;
                    rd_q.push_back(e);
                    e.t = e.t + P;
                    wr_q.push_back(e);
                    n++;
                end
                k = inv ? k - 1 : k + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_en) begin
                logic hit;
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got rd_en=1 a=%0d at edge %0d, required no issue", rd_addr_a, edge_n);
                end else begin
                    iss_t e;
                    e = rd_q.pop_front();
                    chk("rd_issue", pk(edge_n, rd_addr_a, rd_addr_b, zeta_addr, layer), pk(e.t, e.a, e.b, e.z, e.l));
                end
                hit = 1'b0;
                for (int k = 0; k < P; k++)
                    if (pend_v[k] && (pend_a[k] == rd_addr_a || pend_a[k] == rd_addr_b ||
                                      pend_b[k] == rd_addr_a || pend_b[k] == rd_addr_b)) hit = 1'b1;
                chk("rd_hazard", hit, 0);
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got wr_en=1 a=%0d at edge %0d, required no write", wr_addr_a, edge_n);
                end else begin
                    iss_t e;
                    e = wr_q.pop_front();
                    chk("wr_back", pk(edge_n, wr_addr_a, wr_addr_b, 0, 0), pk(e.t, e.a, e.b, 0, 0));
                end
                wcnt[wr_addr_a]++;
                wcnt[wr_addr_b]++;
            end
            for (int k = P - 1; k > 0; k--) begin
                pend_v[k] = pend_v[k-1]; pend_a[k] = pend_a[k-1]; pend_b[k] = pend_b[k-1];
            end
            pend_v[0] = rd_en; pend_a[0] = rd_addr_a; pend_b[0] = rd_addr_b;
            chk("wr1_align", {wr_en_1, wr_addr_a_1, wr_addr_b_1}, hist1[P1-1]);
            for (int k = P1 - 1; k > 0; k--) hist1[k] = hist1[k-1];
            hist1[0] = {rd_en_1, rd_addr_a_1, rd_addr_b_1};
            if (run_active)
                foreach (spots[s])
                    if (spots[s].inv == run_inv && (edge_n - run_base) == spots[s].rel)
                        chk("spot_issue", {rd_en, rd_addr_a, rd_addr_b, zeta_addr},
                            {spots[s].en, 8'(spots[s].a), 8'(spots[s].b), 7'(spots[s].z)});
        end
    end

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 chk("rst_outputs", {rd_en, rd_addr_a, rd_addr_b, zeta_addr, wr_en, wr_addr_a, wr_addr_b,
                               bf_inverse, layer, busy, done, rd_en_1, wr_en_1, busy_1, done_1}, 0);
        rd_q.delete();
        wr_q.delete();
        for (int k = 0; k < P; k++) pend_v[k] = 1'b0;
        for (int k = 0; k < P1; k++) hist1[k] = '0;
        repeat (P + 1) begin
            @(negedge clk);
            chk("rst_quiet", {wr_en, wr_en_1, rd_en, busy}, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_quiet", {wr_en, wr_en_1, busy, busy_1}, 0);
    endtask

    task automatic run_one(input run_t r);
        int   rel, done_rel, done1_rel;
        logic stopped;
        if (!r.b2b) begin
            repeat (2) @(negedge clk);
            chk("idle_outputs", {busy, done, rd_en, wr_en, busy_1, done_1}, 0);
        end
        for (int a = 0; a < 256; a++) wcnt[a] = 0;
        build_model(r.inv, edge_n + 1);
        run_inv = r.inv; run_base = edge_n + 1; run_active = 1'b1;
        inverse = r.inv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; inverse = ~r.inv;
        chk("start_accept", {busy, done, bf_inverse, busy_1, bf_inverse_1}, {1'b1, 1'b0, r.inv, 1'b1, r.inv});
        done_rel = -1; done1_rel = -1; stopped = 1'b0;
        for (int c = 0; c < 1200 && done_rel < 0 && !stopped; c++) begin
            @(negedge clk);
            rel = edge_n - run_base;
            if (done_1 && done1_rel < 0) begin
                done1_rel = rel;
                chk("done1_busy", busy_1, 0);
            end
            if (done) begin
                done_rel = rel;
                chk("done_state", {busy, bf_inverse}, {1'b0, r.inv});
            end
            start = (rel == r.pulse_rel);
            if (rel == r.rst_rel) begin
                do_reset();
                stopped = 1'b1;
            end
        end
        run_active = 1'b0;
        if (r.rst_rel < 0) begin
            chk("done_cycle", 64'(done_rel), 64'(r.exp_done));
            chk("done1_cycle", 64'(done1_rel), 64'(r.exp_done1));
            chk("queues_drained", 64'(rd_q.size() + wr_q.size()), 0);
            for (int a = 0; a < 256; a++) chk("write_count", {32'(a), 32'(wcnt[a])}, {32'(a), 32'd7});
        end
    endtask

    initial begin
        runs[0] = '{inv: 1'b0, pulse_rel: 400, rst_rel: -1,  b2b: 1'b0, exp_done: 918, exp_done1: 904};
        runs[1] = '{inv: 1'b1, pulse_rel: -1,  rst_rel: -1,  b2b: 1'b1, exp_done: 918, exp_done1: 904};
        runs[2] = '{inv: 1'b0, pulse_rel: -1,  rst_rel: 200, b2b: 1'b0, exp_done: -1,  exp_done1: -1};
        runs[3] = '{inv: 1'b0, pulse_rel: -1,  rst_rel: -1,  b2b: 1'b0, exp_done: 918, exp_done1: 904};
        runs[4] = '{inv: 1'b1, pulse_rel: 100, rst_rel: -1,  b2b: 1'b0, exp_done: 918, exp_done1: 904};
        spots[0] = '{1'b0, 1,   1'b1, 0,   128, 1};
        spots[1] = '{1'b0, 2,   1'b1, 1,   129, 1};
        spots[2] = '{1'b0, 3,   1'b1, 2,   130, 1};
        spots[3] = '{1'b0, 787, 1'b1, 0,   2,   64};
        spots[4] = '{1'b0, 789, 1'b1, 4,   6,   65};
        spots[5] = '{1'b1, 1,   1'b1, 0,   2,   127};
        spots[6] = '{1'b1, 3,   1'b1, 4,   6,   126};
        spots[7] = '{1'b1, 787, 1'b1, 0,   128, 1};
        spots[8] = '{1'b1, 914, 1'b1, 127, 255, 1};
        for (int k = 0; k < P; k++) begin pend_v[k] = 1'b0; pend_a[k] = '0; pend_b[k] = '0; end
        for (int k = 0; k < P1; k++) hist1[k] = '0;

        rst = 1'b0; start = 1'b0; inverse = 1'b0;
        #1 rst = 1'b1;
        #1 chk("reset_state", {rd_en, rd_addr_a, rd_addr_b, zeta_addr, wr_en, wr_addr_a, wr_addr_b,
                               bf_inverse, layer, busy, done, rd_en_1, wr_en_1, busy_1, done_1}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;
        for (int r = 0; r < 5; r++) begin
            run_one(runs[r]);
            $display("run %0d inverse=%0d pulse=%0d rst=%0d checks=%0d errors=%0d",
                     r, runs[r].inv, runs[r].pulse_rel, runs[r].rst_rel, checks, errors);
        end
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
